// File: rtl/button_debouncer_pkg.sv
// Shared types and default timing constants for the push-button debouncer.
package button_debouncer_pkg;

  localparam int unsigned CLK_HZ                  = 50_000_000;
  localparam int unsigned DEBOUNCE_MS             = 20;
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;
  localparam int unsigned DEFAULT_CNT_W           = 21;
  localparam int unsigned DEFAULT_PRESS_CNT_W     = 8;

  typedef enum logic [1:0] {
    ST_RELEASED     = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } db_state_e;

  // CPU-visible press handshake flags
  typedef struct packed {
    logic pending;
    logic overrun;
  } press_status_t;

endpackage : button_debouncer_pkg

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous board input.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule : sync_2ff

// File: rtl/button_debouncer.sv
// Debounces an active-low push-button and exposes a press pulse, a press
// counter and a pending/overrun handshake for CPU polling.
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = DEFAULT_CNT_W,
  parameter int unsigned PRESS_CNT_W     = DEFAULT_PRESS_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   btn_raw_n,
  input  logic                   ack,
  output logic                   btn_n,
  output logic                   press_pulse,
  output logic                   pending,
  output logic                   overrun,
  output logic [PRESS_CNT_W-1:0] press_count
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic                   sync_n;
  db_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   btn_n_q, btn_n_d;
  logic                   press_pulse_q, press_pulse_d;
  press_status_t          status_q, status_d;
  logic [PRESS_CNT_W-1:0] press_count_q, press_count_d;
  logic                   accept_c;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_raw_n),
    .q     (sync_n)
  );

  // State register and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RELEASED;
      cnt_q         <= '0;
      btn_n_q       <= 1'b1;
      press_pulse_q <= 1'b0;
      status_q      <= '0;
      press_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      btn_n_q       <= btn_n_d;
      press_pulse_q <= press_pulse_d;
      status_q      <= status_d;
      press_count_q <= press_count_d;
    end
  end

  // Debounce FSM: cnt_q counts consecutive synchronized samples agreeing
  // with the candidate level; it never exceeds DEBOUNCE_CYCLES-1.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    btn_n_d  = btn_n_q;
    accept_c = 1'b0;

    unique case (state_q)
      ST_RELEASED: begin
        if (!sync_n) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end

      ST_PRESS_WAIT: begin
        if (sync_n) begin
          state_d = ST_RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = ST_PRESSED;
          cnt_d    = '0;
          btn_n_d  = 1'b0;
          accept_c = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_PRESSED: begin
        if (sync_n) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end

      ST_RELEASE_WAIT: begin
        if (!sync_n) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_RELEASED;
          cnt_d   = '0;
          btn_n_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = ST_RELEASED;
        cnt_d   = '0;
        btn_n_d = 1'b1;
      end
    endcase
  end

  // Press event, counter and handshake; a new press wins over a same-cycle ack
  always_comb begin
    press_pulse_d = accept_c;
    press_count_d = press_count_q;
    status_d      = status_q;

    if (accept_c) begin
      press_count_d    = press_count_q + PRESS_CNT_W'(1);
      status_d.pending = 1'b1;
      if (!ack && status_q.pending) begin
        status_d.overrun = 1'b1;
      end
    end else if (ack) begin
      status_d.pending = 1'b0;
      status_d.overrun = 1'b0;
    end
  end

  assign btn_n       = btn_n_q;
  assign press_pulse = press_pulse_q;
  assign pending     = status_q.pending;
  assign overrun     = status_q.overrun;
  assign press_count = press_count_q;

endmodule : button_debouncer
